// File: rtl/ram_block_arbiter.sv
// rtl/ram_block_arbiter.sv - two-requester arbiter for the SDRAM block-command port
//
// Serialises whole block transfers from the image-capture writer (IMG) and
// the readout engine (RD) onto one SDRAM command port. IMG has priority.
// RD is guaranteed a grant after at most ImgBurstMax consecutive IMG grants
// made while RD was waiting.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   img_req/img_block IMG level request and block index
//   img_ack/img_done  IMG one-cycle accept / completion pulses
//   rd_req/rd_block   RD level request and block index
//   rd_ack/rd_done    RD one-cycle accept / completion pulses
//   ram_cmd_trigger   command valid to the RAM controller
//   ram_cmd_write     1 = write (IMG), 0 = read (RD)
//   ram_cmd_block     block index of the current command
//   ram_cmd_ready     RAM controller accepts when trigger and ready are high
//   ram_done          one-cycle pulse: current transfer complete
//   busy              high while a transfer is being issued or awaited
//   owner             grant holder, 1 = IMG, 0 = RD; valid while busy
module ram_block_arbiter #(
    parameter int BlockWidth  = 11,
    parameter int ImgBurstMax = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  img_req,
    input  logic [BlockWidth-1:0] img_block,
    output logic                  img_ack,
    output logic                  img_done,
    input  logic                  rd_req,
    input  logic [BlockWidth-1:0] rd_block,
    output logic                  rd_ack,
    output logic                  rd_done,
    output logic                  ram_cmd_trigger,
    output logic                  ram_cmd_write,
    output logic [BlockWidth-1:0] ram_cmd_block,
    input  logic                  ram_cmd_ready,
    input  logic                  ram_done,
    output logic                  busy,
    output logic                  owner
);

    localparam int CntWidth = $clog2(ImgBurstMax + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(ImgBurstMax);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [CntWidth-1:0]   burst_cnt, burst_cnt_d;
    logic                  trigger_d, write_d, owner_d, busy_d;
    logic [BlockWidth-1:0] block_d;
    logic                  img_ack_d, rd_ack_d, img_done_d, rd_done_d;
    logic                  grant_img;

    // IMG wins unless RD is also waiting and IMG has used up its burst.
    assign grant_img = img_req && !(rd_req && (burst_cnt == CntMax));

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt;
        trigger_d   = ram_cmd_trigger;
        write_d     = ram_cmd_write;
        block_d     = ram_cmd_block;
        owner_d     = owner;
        busy_d      = busy;
        img_ack_d   = 1'b0;
        rd_ack_d    = 1'b0;
        img_done_d  = 1'b0;
        rd_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (img_req || rd_req) begin
                    state_d   = ST_ISSUE;
                    trigger_d = 1'b1;
                    busy_d    = 1'b1;
                    owner_d   = grant_img;
                    write_d   = grant_img;
                    block_d   = grant_img ? img_block : rd_block;
                    if (grant_img) begin
                        // Only grants made while RD is waiting count toward starvation.
                        if (rd_req) begin
                            burst_cnt_d = (burst_cnt == CntMax) ? CntMax : burst_cnt + 1'b1;
                        end else begin
                            burst_cnt_d = '0;
                        end
                    end else begin
                        burst_cnt_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (ram_cmd_ready) begin
                    state_d   = ST_WAIT;
                    trigger_d = 1'b0;
                    img_ack_d = owner;
                    rd_ack_d  = !owner;
                end
            end
            ST_WAIT: begin
                if (ram_done) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    img_done_d = owner;
                    rd_done_d  = !owner;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            burst_cnt       <= '0;
            ram_cmd_trigger <= 1'b0;
            ram_cmd_write   <= 1'b0;
            ram_cmd_block   <= '0;
            owner           <= 1'b0;
            busy            <= 1'b0;
            img_ack         <= 1'b0;
            rd_ack          <= 1'b0;
            img_done        <= 1'b0;
            rd_done         <= 1'b0;
        end else begin
            state_q         <= state_d;
            burst_cnt       <= burst_cnt_d;
            ram_cmd_trigger <= trigger_d;
            ram_cmd_write   <= write_d;
            ram_cmd_block   <= block_d;
            owner           <= owner_d;
            busy            <= busy_d;
            img_ack         <= img_ack_d;
            rd_ack          <= rd_ack_d;
            img_done        <= img_done_d;
            rd_done         <= rd_done_d;
        end
    end

endmodule

// File: doc/ram_block_arbiter.md
Name: ram_block_arbiter

Overview:
- Shares the single SDRAM block-command port between two requesters:
  - the image-capture writer (IMG), which streams frames into RAM;
  - the readout engine (RD), which streams RAM blocks out to SD or MSP SPI.
- Sits between both requesters and the SDRAM controller's command port inside the ICE40 app.
- Serialises whole block transfers, gives IMG priority, and bounds RD starvation.

Parameters:
- BlockWidth, 11, width of the RAM block index carried with each command.
- ImgBurstMax, 4, max consecutive IMG grants while RD is waiting; must be at least 1.

Ports:
- clk  in  1  block clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- img_req  in  1  IMG requests a write of block img_block; held until img_ack.
- img_block  in  BlockWidth  block index for IMG.
- img_ack  out  1  one-cycle pulse: IMG request accepted by the RAM controller.
- img_done  out  1  one-cycle pulse: IMG transfer finished.
- rd_req  in  1  RD requests a read of block rd_block; held until rd_ack.
- rd_block  in  BlockWidth  block index for RD.
- rd_ack  out  1  one-cycle pulse: RD request accepted.
- rd_done  out  1  one-cycle pulse: RD transfer finished.
- ram_cmd_trigger  out  1  command valid to the RAM controller.
- ram_cmd_write  out  1  1 = write (IMG), 0 = read (RD).
- ram_cmd_block  out  BlockWidth  block index of the current command.
- ram_cmd_ready  in  1  RAM controller accepts the command when trigger and ready are both high.
- ram_done  in  1  one-cycle pulse: current transfer complete.
- busy  out  1  high in Issue and Wait.
- owner  out  1  grant holder: 1 = IMG, 0 = RD; valid while busy.

Behaviour:
Reset:
- After rst, all outputs are 0, the state is Idle, and the starvation counter burst_cnt is 0.
- rst high in any state aborts the transaction next edge.
- Any ram_done pulse while rst is high is ignored.
States: Idle, Issue, Wait.
Idle:
- Neither requester asserting: remain in Idle.
- Grant rule (decided combinationally from that cycle's inputs):
  - only img_req: grant IMG;
  - only rd_req: grant RD;
  - both asserting: grant RD if burst_cnt == ImgBurstMax, otherwise grant IMG.
- On a grant, on the same edge:
  - latch the owner, direction, and block into ram_cmd_write and ram_cmd_block;
  - go to Issue.
- ram_cmd_trigger is registered and is first high the cycle after the grant.
Issue:
- ram_cmd_trigger stays high, with block and write held stable, until ram_cmd_ready is sampled high.
- On that edge:
  - ram_cmd_trigger drops;
  - the owner's ack pulses for exactly the next cycle;
  - go to Wait.
- Latency from req to ack is at least 2 cycles, when ready is already high.
Wait:
- On ram_done:
  - the owner's done pulses next cycle;
  - go to Idle.
- A new grant is possible no earlier than the cycle after done asserts (no back-to-back overlap).
- ram_done outside Wait is ignored.
burst_cnt update, applied when an IMG grant is made:
- rd_req high: increment, saturating at ImgBurstMax;
- rd_req low: reset to 0.
- Any RD grant resets it to 0.
Request handling:
- Requests are level, sampled only in Idle.
- A requester dropping req before ack has no effect once it has been granted; the command still completes.
- The requester must hold its block stable only until the grant edge.
Outputs:
- Only one of img_ack and rd_ack, and only one of img_done and rd_done, is ever high in a cycle.
- All outputs are registered.

Test Plan:
- Reset: assert rst 2 cycles with img_req = 1 → all outputs 0 throughout; the first ram_cmd_trigger appears 2 cycles after rst falls.
- Single IMG with delayed ready: img_req, img_block = 0x05, ram_cmd_ready low for 3 cycles → trigger held 4 cycles with write = 1 and block = 0x05 stable; img_ack pulses 1 cycle; ram_done → img_done 1 cycle later; busy falls.
- Single RD: rd_req, rd_block = 0x7FF, ready = 1 → trigger with write = 0 and block = 0x7FF; rd_ack then rd_done pulses; img_ack and img_done stay 0.
- Starvation bound with ImgBurstMax = 4: img_req and rd_req held continuously → grant order IMG×4, RD, IMG×4, RD.
- Starvation counter reset: with rd_req low, 4 IMG grants leave burst_cnt = 0; rd_req then rises → the next 4 grants go to IMG before RD.
- Abort: rst asserted in Wait, then ram_done pulsed → no done pulse; state Idle; the next request is granted normally.
